// File: rtl/rv_register_file.sv
// rv_register_file
//   Integer register file for the single-cycle RV32I core: 32 x 32-bit
//   registers with x0 hardwired to zero. Two combinational read ports feed
//   the ALU operands; one write port, sampled on the rising clock edge,
//   takes the writeback result.
//
// Ports
//   clk  in   1  core clock, all state changes on its rising edge
//   rst  in   1  synchronous active-high reset, clears every register
//   A1   in   5  read address, port 1 (rs1)
//   A2   in   5  read address, port 2 (rs2)
//   A3   in   5  write address (rd)
//   WE3  in   1  write enable, active high
//   WD3  in  32  write data
//   RD1  out 32  x[A1]
//   RD2  out 32  x[A2]
module rv_register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [4:0]  A3,
  input  logic        WE3,
  input  logic [31:0] WD3,
  output logic [31:0] RD1,
  output logic [31:0] RD2
);

  logic [31:0] regs_reg [0:31];
  logic [31:0] wsel;

  // One-hot write select. Entry 0 is never selected, so writes to x0 are
  // dropped here rather than relying on the read mux alone.
  assign wsel[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_wsel
      assign wsel[gi] = WE3 && (A3 == 5'(gi));
    end
  endgenerate

  // Reset wins over a coincident write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (rst) begin
        regs_reg[i] <= '0;
      end else if (wsel[i]) begin
        regs_reg[i] <= WD3;
      end
    end
  end

  // Address 0 is forced to zero so x0 reads clean even before the first
  // reset, when the storage itself is still undefined.
  assign RD1 = (A1 == 5'd0) ? 32'd0 : regs_reg[A1];
  assign RD2 = (A2 == 5'd0) ? 32'd0 : regs_reg[A2];

endmodule

// File: tb/tb_rv_register_file.sv
module tb_rv_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [4:0]  A3;
  logic        WE3;
  logic [31:0] WD3;
  logic [31:0] RD1;
  logic [31:0] RD2;

  rv_register_file dut (
    .clk (clk),
    .rst (rst),
    .A1  (A1),
    .A2  (A2),
    .A3  (A3),
    .WE3 (WE3),
    .WD3 (WD3),
    .RD1 (RD1),
    .RD2 (RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } sb_t;

  localparam int NVEC = 9;
  vec_t tbl [NVEC];
  sb_t  sbq [$];
  sb_t  sb;
  int   errors;
  int   checks;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; WE3 = 1'b0; A3 = 5'd0; WD3 = 32'd0; A1 = 5'd0; A2 = 5'd0;

    // Expected values are post-edge reads, derived from the write history.
    //           rst   we    a3     wd             a1     a2     exp1           exp2
    tbl[0] = '{1'b0, 1'b1, 5'd5,  32'h2B34_5FD4, 5'd5,  5'd5,  32'h2B34_5FD4, 32'h2B34_5FD4};
    tbl[1] = '{1'b0, 1'b0, 5'd10, 32'hA391_FFC3, 5'd10, 5'd5,  32'h0000_0000, 32'h2B34_5FD4};
    tbl[2] = '{1'b0, 1'b0, 5'd10, 32'hA391_FFC3, 5'd10, 5'd5,  32'h0000_0000, 32'h2B34_5FD4};
    tbl[3] = '{1'b0, 1'b0, 5'd10, 32'hA391_FFC3, 5'd10, 5'd5,  32'h0000_0000, 32'h2B34_5FD4};
    tbl[4] = '{1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd5,  32'h0000_0000, 32'h2B34_5FD4};
    tbl[5] = '{1'b0, 1'b1, 5'd7,  32'h1111_1111, 5'd7,  5'd0,  32'h1111_1111, 32'h0000_0000};
    tbl[6] = '{1'b0, 1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd7,  32'hCAFE_F00D, 32'h1111_1111};
    tbl[7] = '{1'b0, 1'b1, 5'd31, 32'h1234_5678, 5'd31, 5'd5,  32'h1234_5678, 32'h2B34_5FD4};
    tbl[8] = '{1'b0, 1'b1, 5'd1,  32'h0000_0001, 5'd1,  5'd31, 32'h0000_0001, 32'h1234_5678};

    // x0 reads zero even before any reset.
    #1;
    chk("x0_before_reset_rd1", RD1, 32'd0);
    chk("x0_before_reset_rd2", RD2, 32'd0);

    // Reset, then sweep all addresses on both ports.
    step();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      A1 = 5'(a);
      A2 = 5'(31 - a);
      #1;
      chk($sformatf("reset_sweep_rd1_x%0d", a), RD1, 32'd0);
      chk($sformatf("reset_sweep_rd2_x%0d", 31 - a), RD2, 32'd0);
    end
    $display("txn reset sweep done");

    // Table vectors: expected result queued when driven, checked after the edge.
    for (int v = 0; v < NVEC; v++) begin
      rst = tbl[v].rst; WE3 = tbl[v].we; A3 = tbl[v].a3; WD3 = tbl[v].wd;
      A1 = tbl[v].a1; A2 = tbl[v].a2;
      sbq.push_back('{v, tbl[v].exp1, tbl[v].exp2});
      step();
      WE3 = 1'b0;
      #1;
      sb = sbq.pop_front();
      chk($sformatf("vec%0d_rd1", sb.idx), RD1, sb.exp1);
      chk($sformatf("vec%0d_rd2", sb.idx), RD2, sb.exp2);
      $display("txn vec%0d we=%0b a3=%0d wd=%h -> rd1=%h rd2=%h", v, tbl[v].we, tbl[v].a3, tbl[v].wd, RD1, RD2);
    end

    // Read addresses moved mid-cycle: outputs follow without an edge.
    A1 = 5'd0; A2 = 5'd0;
    #1;
    A1 = 5'd5; A2 = 5'd5;
    #1;
    chk("midcycle_rd1_x5", RD1, 32'h2B34_5FD4);
    chk("midcycle_rd2_x5", RD2, 32'h2B34_5FD4);
    $display("txn midcycle read x5 rd1=%h rd2=%h", RD1, RD2);

    // Read during write: old value before the edge, new value after.
    WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h2222_2222; A1 = 5'd7; A2 = 5'd7;
    #1;
    chk("rdw_before_rd1", RD1, 32'h1111_1111);
    chk("rdw_before_rd2", RD2, 32'h1111_1111);
    step();
    WE3 = 1'b0;
    #1;
    chk("rdw_after_rd1", RD1, 32'h2222_2222);
    $display("txn read-during-write x7 rd1=%h", RD1);

    // Write enable pulsed between edges only: nothing is committed.
    A3 = 5'd9; WD3 = 32'h5555_AAAA; A1 = 5'd9;
    WE3 = 1'b1;
    #1;
    WE3 = 1'b0;
    step();
    chk("we_glitch_x9", RD1, 32'd0);
    $display("txn we glitch x9 rd1=%h", RD1);

    // Reset and write on the same edge: reset wins and clears everything.
    rst = 1'b1; WE3 = 1'b1; A3 = 5'd3; WD3 = 32'hDEAD_BEEF;
    step();
    rst = 1'b0; WE3 = 1'b0;
    A1 = 5'd3; A2 = 5'd5;
    #1;
    chk("rst_vs_wr_x3", RD1, 32'd0);
    chk("rst_vs_wr_x5", RD2, 32'd0);
    A1 = 5'd7; A2 = 5'd31;
    #1;
    chk("rst_vs_wr_x7", RD1, 32'd0);
    chk("rst_vs_wr_x31", RD2, 32'd0);
    $display("txn reset vs write x3 cleared");

    // Register usable again after the reset.
    WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h0BAD_CAFE; A1 = 5'd3;
    step();
    WE3 = 1'b0;
    #1;
    chk("post_reset_write_x3", RD1, 32'h0BAD_CAFE);
    $display("txn post-reset write x3 rd1=%h", RD1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
